// File: rtl/keypad_scanner.sv
// Row-multiplexed keypad scanner with per-key debounce and a one-deep press/release event slot.
// Define KB_RELEASE_EVENT_EN to also report key releases through the event slot.
module keypad_scanner #(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 4,
  parameter  int SCAN_DIV = 1000,
  parameter  int DEBOUNCE = 4,
  localparam int KEYS     = ROWS * COLS,
  localparam int CODE_W   = ($clog2(KEYS) < 1) ? 1 : $clog2(KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_signal,
  output logic [ROWS-1:0]   row_en,
  output logic [KEYS-1:0]   key_state,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_release,
  input  logic              key_ready
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int CNT_W   = $clog2(DEBOUNCE + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE);

`ifdef KB_RELEASE_EVENT_EN
  localparam bit REL_EV = 1'b1;
`else
  localparam bit REL_EV = 1'b0;
`endif

  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]   cnt_q [KEYS];
  logic [CNT_W-1:0]   cnt_d [KEYS];
  logic [KEYS-1:0]    key_state_q, key_state_d;
  logic               key_valid_q, key_valid_d;
  logic [CODE_W-1:0]  key_code_q, key_code_d;
  logic               key_release_q, key_release_d;

  logic               sample;
  logic               slot_free;
  logic               found;
  logic [CODE_W-1:0]  flip_idx;
  logic               flip_rel;
  logic               gen_ev;
  logic [CODE_W-1:0]  idx;
  logic               raw;
  logic [CNT_W-1:0]   nxt;

  assign sample = (dwell_q == DWELL_LAST);

  // Row scan timing: dwell counter wraps every SCAN_DIV cycles and steps the driven row
  always_comb begin
    dwell_d = dwell_q + 1'b1;
    row_d   = row_q;
    if (sample) begin
      dwell_d = '0;
      row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  // Debounce update for the driven row and single-slot event arbitration
  always_comb begin
    cnt_d         = cnt_q;
    key_state_d   = key_state_q;
    key_valid_d   = key_valid_q;
    key_code_d    = key_code_q;
    key_release_d = key_release_q;
    slot_free     = ~key_valid_q | key_ready;
    found         = 1'b0;
    flip_idx      = '0;
    flip_rel      = 1'b0;
    gen_ev        = 1'b0;
    idx           = '0;
    raw           = 1'b0;
    nxt           = '0;

    if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end

    if (sample) begin
      for (int c = 0; c < COLS; c++) begin
        idx = CODE_W'(int'(row_q) * COLS + c);
        raw = ~col_signal[c];
        if (raw == key_state_q[idx]) begin
          nxt = '0;
        end else if (cnt_q[idx] == CNT_MAX) begin
          nxt = CNT_MAX;
        end else begin
          nxt = cnt_q[idx] + 1'b1;
        end
        cnt_d[idx] = nxt;
        // Lowest column wins; other saturated keys wait for a later sample of this row
        if (nxt == CNT_MAX && !found) begin
          found    = 1'b1;
          flip_idx = idx;
          flip_rel = key_state_q[idx];
        end
      end

      if (found) begin
        gen_ev = ~flip_rel | REL_EV;
        if (!gen_ev || slot_free) begin
          key_state_d[flip_idx] = ~key_state_q[flip_idx];
          cnt_d[flip_idx]       = '0;
          if (gen_ev) begin
            key_valid_d   = 1'b1;
            key_code_d    = flip_idx;
            key_release_d = flip_rel;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q       <= '0;
      row_q         <= '0;
      cnt_q         <= '{default: '0};
      key_state_q   <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_release_q <= 1'b0;
    end else begin
      dwell_q       <= dwell_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      key_state_q   <= key_state_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_release_q <= key_release_d;
    end
  end

  assign row_en      = ~(ROWS'(1) << row_q);
  assign key_state   = key_state_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner (4x4, SCAN_DIV=4, DEBOUNCE=3) with a behavioural keypad and event scoreboard.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;

`ifdef KB_RELEASE_EVENT_EN
  localparam bit REL_EV = 1'b1;
`else
  localparam bit REL_EV = 1'b0;
`endif

  typedef struct {
    logic [3:0] code;
    logic       rel;
  } ev_t;

  typedef struct {
    int          cyc;
    logic        ready;
    logic [3:0]  exp_row;
    logic        exp_vld;
    logic [15:0] exp_st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_signal;
  logic [3:0]  row_en;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_release;
  logic        key_ready = 1'b0;
  logic [15:0] pressed = '0;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  ev_t  sb[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .rst(rst), .col_signal(col_signal), .row_en(row_en),
    .key_state(key_state), .key_valid(key_valid), .key_code(key_code),
    .key_release(key_release), .key_ready(key_ready)
  );

  // Keypad matrix: a closed key pulls its column low while its row is driven
  always_comb begin
    col_signal = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_en[r] && pressed[r*COLS+c]) col_signal[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pressed = '0;
    key_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    sb.delete();
  endtask

  task automatic check_ev(input string name);
    ev_t e;
    chk({name, "_valid"}, key_valid, 1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb actual=event required=nothing queued", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_code"}, key_code, e.code);
      chk({name, "_rel"}, key_release, e.rel);
    end
  endtask

  // Consume events with key_ready=1 for n cycles, comparing each against the scoreboard
  task automatic drain(input int n);
    ev_t e;
    key_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (key_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event actual=code %0d rel %0d required=no event", key_code, key_release);
        end else begin
          e = sb.pop_front();
          chk("ev_code", key_code, e.code);
          chk("ev_rel", key_release, e.rel);
        end
      end
    end
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int hold_bad;

    vecs[0] = '{0,  1'b0, 4'b1110, 1'b0, 16'h0};
    vecs[1] = '{3,  1'b0, 4'b1110, 1'b0, 16'h0};
    vecs[2] = '{4,  1'b0, 4'b1101, 1'b0, 16'h0};
    vecs[3] = '{7,  1'b0, 4'b1101, 1'b0, 16'h0};
    vecs[4] = '{8,  1'b1, 4'b1011, 1'b0, 16'h0};
    vecs[5] = '{12, 1'b1, 4'b0111, 1'b0, 16'h0};
    vecs[6] = '{15, 1'b0, 4'b0111, 1'b0, 16'h0};
    vecs[7] = '{16, 1'b1, 4'b1110, 1'b0, 16'h0};
    vecs[8] = '{19, 1'b0, 4'b1110, 1'b0, 16'h0};

    // Idle scan after reset
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_to(vecs[i].cyc);
      key_ready = vecs[i].ready;
      chk("row_en", row_en, vecs[i].exp_row);
      chk("idle_valid", key_valid, vecs[i].exp_vld);
      chk("idle_state", key_state, vecs[i].exp_st);
    end

    // Key 9 held: flips on the third row-2 sample (cycle 43), event visible at 44
    do_reset();
    key_ready = 1'b1;
    pressed = 16'h0200;
    sb.push_back('{code: 4'd9, rel: 1'b0});
    run_to(43);
    chk("pre_flip_valid", key_valid, 0);
    chk("pre_flip_state9", key_state[9], 0);
    run_to(44);
    chk("flip_state9", key_state[9], 1);
    check_ev("press9");
    run_to(45);
    chk("popped_valid", key_valid, 0);
    pressed = '0;
    if (REL_EV) sb.push_back('{code: 4'd9, rel: 1'b1});
    drain(96);
    chk("release_state9", key_state[9], 0);

    // Key 9 bounce: two samples closed then open
    do_reset();
    key_ready = 1'b1;
    pressed = 16'h0200;
    run_to(30);
    pressed = '0;
    drain(96);
    chk("bounce_state9", key_state[9], 0);

    // Keys 3 and 9 with consumer stalled: key 9 deferred until the slot drains
    do_reset();
    key_ready = 1'b0;
    pressed = 16'h0208;
    sb.push_back('{code: 4'd3, rel: 1'b0});
    sb.push_back('{code: 4'd9, rel: 1'b0});
    run_to(35);
    chk("stall_pre_valid", key_valid, 0);
    run_to(36);
    hold_bad = 0;
    while (cyc < 356) begin
      if (!key_valid || key_code != 4'd3 || key_release || key_state != 16'h0008) hold_bad++;
      step();
    end
    chk("hold_unstable_cycles", hold_bad, 0);
    chk("hold_state9", key_state[9], 0);
    check_ev("held3");
    key_ready = 1'b1;
    run_to(357);
    chk("after_pop_valid", key_valid, 0);
    run_to(363);
    chk("before_row2_valid", key_valid, 0);
    run_to(364);
    check_ev("deferred9");
    chk("state_3_9", key_state, 16'h0208);
    run_to(365);
    pressed = '0;
    if (REL_EV) begin
      sb.push_back('{code: 4'd3, rel: 1'b1});
      sb.push_back('{code: 4'd9, rel: 1'b1});
    end
    drain(96);
    chk("stall_release_state", key_state, 16'h0);

    // Keys 4 and 6 on the same row: lowest column first, then release of 6
    do_reset();
    pressed = 16'h0050;
    sb.push_back('{code: 4'd4, rel: 1'b0});
    sb.push_back('{code: 4'd6, rel: 1'b0});
    drain(96);
    chk("state_4_6", key_state, 16'h0050);
    pressed = 16'h0010;
    if (REL_EV) sb.push_back('{code: 4'd6, rel: 1'b1});
    drain(96);
    chk("state_after_rel6", key_state, 16'h0010);
    chk("key_release_level", key_release, REL_EV);

    // Reset with an event held and another deferred
    do_reset();
    key_ready = 1'b0;
    pressed = 16'h0208;
    run_to(50);
    chk("pre_rst_valid", key_valid, 1);
    chk("pre_rst_code", key_code, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pressed = '0;
    cyc = 0;
    sb.delete();
    chk("rst_valid", key_valid, 0);
    chk("rst_state", key_state, 16'h0);
    chk("rst_row_en", row_en, 4'b1110);
    chk("rst_code", key_code, 0);
    drain(96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of driven keypad rows (2..8).
REQ-002 Parameter COLS, default 4, number of sensed keypad columns (2..8).
REQ-003 Parameter SCAN_DIV, default 1000, clock cycles each row is driven (>=2).
REQ-004 Parameter DEBOUNCE, default 4, consecutive identical row samples needed to change a key state (1..15).
REQ-005 Derived CODE_W = clog2(ROWS*COLS), minimum 1.
REQ-006 Port clk  in  1  single clock; all logic on rising edge.
REQ-007 Port rst  in  1  reset; synchronous, active-high.
REQ-008 Port col_signal  in  COLS  column sense, active-low (0 = key closed on the driven row).
REQ-009 Port row_en  out  ROWS  row drive, active-low, exactly one bit low at all times.
REQ-010 Port key_state  out  ROWS*COLS  debounced bitmap, bit r*COLS+c = 1 while key (r,c) is pressed.
REQ-011 Port key_valid  out  1  event slot holds an event.
REQ-012 Port key_code  out  CODE_W  key index r*COLS+c of the held event.
REQ-013 Port key_release  out  1  held event type: 0 press, 1 release.
REQ-014 Port key_ready  in  1  consumer accepts the event when key_valid=1.

Function
REQ-015 Dwell counter counts 0..SCAN_DIV-1 and wraps; row index advances (ROWS-1 wraps to 0) on the wrap; row_en = ~(1<<row).
REQ-016 Columns are sampled only on the cycle dwell = SCAN_DIV-1; raw(c) = ~col_signal(c) for the current row.
REQ-017 Each key has a counter of width clog2(DEBOUNCE+1); on its row's sample: raw == key_state bit -> counter cleared; raw != state -> counter increments, saturating at DEBOUNCE.
REQ-018 A key is eligible to flip when its counter equals DEBOUNCE after the sample update.
REQ-019 At most one key flips per sample: the lowest column index among eligible keys of that row; others keep saturated counters and re-qualify on later samples of that row.
REQ-020 A flip that generates an event occurs only if the slot is free or popped that cycle (key_valid=0, or key_valid=1 and key_ready=1); otherwise the flip is deferred; no event is ever lost or reordered.
REQ-021 On flip: key_state bit toggles, counter clears, and if the flip produces an event the slot loads key_code and key_release, with key_valid=1 the next cycle.
REQ-022 key_valid, key_code, key_release stay stable until key_valid=1 and key_ready=1 in the same cycle; a pop and a load in the same cycle leave key_valid=1 with the new event.
REQ-023 key_state reflects flips on the cycle after the flip; it is never altered by the handshake.

Reset
REQ-024 While rst=1 on a clock edge: row=0 (row_en = all ones except bit 0 low), dwell=0, all counters=0, key_state=0, key_valid=0, key_code=0, key_release=0.
REQ-025 Reset mid-operation discards any held or deferred event without emitting it.

Configuration
REQ-026 Macro KB_RELEASE_EVENT_EN defined: releases produce events with key_release=1 and obey REQ-020.
REQ-027 Macro KB_RELEASE_EVENT_EN undefined: releases flip key_state without slot use or deferral, key_release is tied 0, and only presses generate events.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, macro defined unless stated)
REQ-028 Reset then idle -> row_en=1110, cycles 4..7 1101, cycles 16..19 1110 again; key_valid=0, key_state=0.
REQ-029 Key 9 (row 2, col 1) held, key_ready=1 -> key_state[9]=1 and key_valid=1, key_code=9, key_release=0 after the 3rd row-2 sample; popped next cycle.
REQ-030 Key 9 closed for 2 row-2 samples, then open -> no event, key_state[9] stays 0.
REQ-031 Keys 3 and 9 pressed together, key_ready=0 for 20 frames -> event 3 held stable, key_state[9]=0; after pop, event 9 appears at the next row-2 sample.
REQ-032 Keys 4 and 6 pressed together -> event 4 first, event 6 at the following row-1 sample; press then release of 6 -> release event code 6 (macro defined) or no release event and key_release=0 (undefined).
REQ-033 rst=1 for one cycle while key_valid=1 and a flip is deferred -> next cycle key_valid=0, key_state=0, row_en=1110.
